retire_monitor: RTL and testbench
=================================

Name: retire_monitor

Overview:
- Run-control and retirement monitor that consumes the WB-stage retire stream (valid, pc, instr) of the CPU.
- Counts cycles and retired instructions, and detects program end when the halt address retires.
- A watchdog catches a hung pipeline.
- Produces sticky done/halted/timeout flags and statistics; the testbench polls these instead of comparing PCs itself.

Parameters:
- XLEN, 32, width of pc/instr buses.
- HALT_PC, 32'h00000078, address whose retirement ends the run.
- WDOG_CYCLES, 1024, maximum consecutive RUN cycles without a retire before timeout (must be >= 2).
- CNT_W, 32, width of the cycle and retire counters.

Ports:
- clk, input, 1, system clock, rising edge.
- rstn, input, 1, reset; synchronous, active-high (asserted = 1).
- start, input, 1, one-cycle pulse that begins monitoring; ignored outside IDLE.
- wb_valid, input, 1, an instruction retires this cycle.
- wb_pc, input, XLEN, PC of the retiring instruction.
- wb_instr, input, XLEN, encoding of the retiring instruction.
- running, output, 1, FSM in RUN.
- done, output, 1, run finished (halted or timeout); sticky.
- halted, output, 1, finished by HALT_PC retire; sticky.
- timeout, output, 1, finished by watchdog; sticky.
- cycle_cnt, output, CNT_W, clock cycles spent in RUN.
- retire_cnt, output, CNT_W, instructions retired in RUN.
- last_pc, output, XLEN, PC of the most recent retire.

Behaviour:
- All outputs are registered.
- Reset (rstn=1 at a rising edge):
  - FSM goes to IDLE.
  - running, done, halted, timeout, cycle_cnt, retire_cnt, last_pc, and the watchdog count all go to 0.
  - Reset overrides every other event, including mid-RUN; all statistics are lost.
- FSM states: IDLE, RUN, HALT, TMO.
- IDLE:
  - Retires are ignored and counters hold.
  - start=1 -> RUN next cycle; running=1 from that cycle.
- RUN, every cycle:
  - cycle_cnt increments by 1, saturating at all-ones (no wrap).
  - If wb_valid=1:
    - retire_cnt increments, also saturating.
    - last_pc <= wb_pc.
    - Watchdog clears to 0.
  - If wb_valid=0: watchdog increments.
- RUN exits:
  - wb_valid=1 and wb_pc==HALT_PC -> HALT.
    - The halting retire is itself counted in retire_cnt and last_pc.
    - halted=1, done=1, running=0 visible the cycle after the retire is sampled (1-cycle latency).
  - wb_valid=0 and watchdog==WDOG_CYCLES-1 -> TMO.
    - timeout=1, done=1, running=0 next cycle.
    - cycle_cnt includes the expiring cycle.
- Simultaneous events: a halting retire in the expiring cycle cannot time out, because the retire clears the watchdog. Halt always has priority over timeout.
- HALT/TMO: terminal until reset. Counters, last_pc and flags freeze; start and wb_* are ignored.
- Invariants: done == halted | timeout; halted and timeout are never both 1.
- wb_instr is used only by the optional feature; without it the input is unused.

Optional Feature:
- Macro: RETIRE_MON_SPIN_DETECT_EN.
- Defined:
  - A retire in RUN with wb_instr==32'h0000006f (jal x0,0, jump-to-self) is also treated as a halt (-> HALT, halted=1).
  - This lets programs end with an idle loop at any address.
  - Priority and latency are the same as for HALT_PC.
- Undefined: wb_instr is ignored; only HALT_PC or the watchdog end a run.

Decomposition:
- Package retire_mon_pkg holds:
  - the state enum (ST_IDLE, ST_RUN, ST_HALT, ST_TMO);
  - constant INSTR_JAL_SELF = 32'h0000006f;
  - default HALT_PC.
- Sub-module sat_counter (parameter W; inputs clr, inc; output q; saturates at all-ones).
  - Instantiated for cycle_cnt, retire_cnt and the watchdog (watchdog uses clr on retire).

Test Plan:
- Reset then start; retire pc 0x00,0x04,...,0x78 one per cycle (31 retires) -> the cycle after the 0x78 retire: halted=1, done=1, running=0, retire_cnt=31, cycle_cnt=31, last_pc=0x78.
- WDOG_CYCLES=8; start, no retires -> timeout=1 after exactly 8 RUN cycles, cycle_cnt=8, retire_cnt=0, halted=0.
- WDOG_CYCLES=8; 7 idle cycles then a retire of pc 0x78 in the 8th -> halted=1, timeout=0 (halt priority, watchdog cleared).
- Retires before start, and retires after HALT -> counters stay 0 pre-start and frozen post-halt; second start after halt has no effect.
- Assert rstn mid-RUN with retire_cnt=5 -> next cycle all outputs 0, FSM IDLE; new start resumes counting from 0.
- With RETIRE_MON_SPIN_DETECT_EN: retire pc 0x40, instr 0x0000006f -> halted=1, last_pc=0x40. Without it: no halt, monitoring continues.

Source files
------------

// File: rtl/retire_mon_pkg.sv
// Shared types and constants for the retire monitor: FSM state encoding,
// the jump-to-self encoding and the default halt address.
package retire_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_TMO  = 2'd3
  } state_e;

  localparam logic [31:0] INSTR_JAL_SELF  = 32'h0000_006f;
  localparam logic [31:0] DEFAULT_HALT_PC = 32'h0000_0078;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// clr wins over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/retire_monitor.sv
// Run-control / retirement monitor: counts RUN cycles and retires, ends the run
// on a HALT_PC retire or watchdog expiry. Optional RETIRE_MON_SPIN_DETECT_EN
// also ends the run on a retired jump-to-self.
module retire_monitor
  import retire_mon_pkg::*;
#(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  HALT_PC     = XLEN'(DEFAULT_HALT_PC),
  parameter int               WDOG_CYCLES = 1024,
  parameter int               CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [XLEN-1:0]  wb_instr,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [XLEN-1:0]  last_pc
);

  localparam int            WD_W    = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  state_e          state_q, state_d;
  logic            in_run;
  logic            halt_hit;
  logic            spin_hit;
  logic [WD_W-1:0] wdog_q;
  logic [XLEN-1:0] last_pc_q;
  logic            running_q, halted_q, timeout_q;

  assign in_run = (state_q == ST_RUN);

`ifdef RETIRE_MON_SPIN_DETECT_EN
  assign spin_hit = (wb_instr == XLEN'(INSTR_JAL_SELF));
`else
  logic unused_instr;
  assign unused_instr = ^wb_instr;
  assign spin_hit     = 1'b0;
`endif

  assign halt_hit = wb_valid && ((wb_pc == HALT_PC) || spin_hit);

  // A retire clears the watchdog, so halt is checked first and always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (halt_hit) begin
          state_d = ST_HALT;
        end else if (!wb_valid && (wdog_q == WD_LAST)) begin
          state_d = ST_TMO;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      last_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      halted_q  <= (state_d == ST_HALT);
      timeout_q <= (state_d == ST_TMO);
      if (in_run && wb_valid) last_pc_q <= wb_pc;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk), .srst(rstn), .clr(1'b0), .inc(in_run), .q(cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk (clk), .srst(rstn), .clr(1'b0), .inc(in_run && wb_valid), .q(retire_cnt)
  );

  sat_counter #(.W(WD_W)) u_wdog (
    .clk (clk), .srst(rstn), .clr(in_run && wb_valid), .inc(in_run && !wb_valid), .q(wdog_q)
  );

  assign running = running_q;
  assign halted  = halted_q;
  assign timeout = timeout_q;
  assign done    = halted_q | timeout_q;
  assign last_pc = last_pc_q;

endmodule

// File: tb/tb_retire_monitor.sv
// Directed self-checking bench for retire_monitor (WDOG_CYCLES=8, HALT_PC=0x78).
// Covers halt, timeout, halt-vs-timeout priority, freeze, mid-run reset and spin detect.
module tb_retire_monitor;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_instr;
  logic        running, done, halted, timeout;
  logic [31:0] cycle_cnt, retire_cnt, last_pc;

  int checks = 0;
  int errors = 0;

  retire_monitor #(
    .XLEN(32), .HALT_PC(32'h0000_0078), .WDOG_CYCLES(8), .CNT_W(32)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_instr(wb_instr), .running(running), .done(done), .halted(halted),
    .timeout(timeout), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .last_pc(last_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // flags packed as {running, done, halted, timeout}
  task automatic check_all(input string tag, input logic [3:0] flags,
                           input logic [31:0] cyc, input logic [31:0] ret, input logic [31:0] pc);
    check({tag, ".flags"}, {28'd0, running, done, halted, timeout}, {28'd0, flags});
    check({tag, ".cycle_cnt"}, cycle_cnt, cyc);
    check({tag, ".retire_cnt"}, retire_cnt, ret);
    check({tag, ".last_pc"}, last_pc, pc);
    $display("step %-16s run=%0b done=%0b halt=%0b tmo=%0b cyc=%0d ret=%0d pc=0x%0h",
             tag, running, done, halted, timeout, cycle_cnt, retire_cnt, last_pc);
  endtask

  task automatic do_reset();
    rstn = 1'b1; start = 1'b0; wb_valid = 1'b0; wb_pc = '0; wb_instr = 32'h13;
    tick();
    rstn = 1'b0;
  endtask

  initial begin
    // 1: reset state, then straight-line run to HALT_PC
    do_reset();
    check_all("reset", 4'b0000, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all("started", 4'b1000, 0, 0, 0);
    for (int i = 0; i < 31; i++) begin
      wb_valid = 1'b1; wb_pc = 32'(i * 4);
      tick();
      if (i == 14) check_all("mid_run", 4'b1000, 15, 15, 32'h38);
    end
    wb_valid = 1'b0;
    check_all("halt_pc", 4'b0110, 31, 31, 32'h78);

    // 2: retires and a second start after HALT are ignored
    wb_valid = 1'b1; wb_pc = 32'h200; start = 1'b1;
    tick(); tick(); tick();
    start = 1'b0; wb_valid = 1'b0;
    check_all("post_halt", 4'b0110, 31, 31, 32'h78);

    // 3: retires before start ignored, then pure watchdog timeout
    do_reset();
    wb_valid = 1'b1; wb_pc = 32'h78;
    tick(); tick(); tick();
    wb_valid = 1'b0;
    check_all("pre_start", 4'b0000, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_all("wdog_7", 4'b1000, 7, 0, 0);
    tick();
    check_all("wdog_tmo", 4'b0101, 8, 0, 0);
    tick(); tick();
    check_all("tmo_frozen", 4'b0101, 8, 0, 0);

    // 4: halting retire in the expiring cycle beats the watchdog
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    wb_valid = 1'b1; wb_pc = 32'h78;
    tick();
    wb_valid = 1'b0;
    check_all("halt_prio", 4'b0110, 8, 1, 32'h78);

    // 5: a retire clears the watchdog, so 7 more idle cycles do not time out
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    wb_valid = 1'b1; wb_pc = 32'h10;
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_all("wdog_clr", 4'b1000, 13, 1, 32'h10);
    tick();
    check_all("wdog_clr_tmo", 4'b0101, 14, 1, 32'h10);

    // 6: reset mid-RUN wipes everything; new start counts from zero
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1'b1; wb_pc = 32'h100 + 32'(i * 4);
      tick();
    end
    check_all("pre_rst", 4'b1000, 5, 5, 32'h110);
    rstn = 1'b1; wb_pc = 32'h78;
    tick();
    rstn = 1'b0; wb_valid = 1'b0;
    check_all("mid_rst", 4'b0000, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wb_valid = 1'b1; wb_pc = 32'h300;
    tick();
    wb_pc = 32'h304;
    tick();
    wb_valid = 1'b0;
    check_all("restart", 4'b1000, 2, 2, 32'h304);

    // 7: retire of jump-to-self away from HALT_PC
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    wb_valid = 1'b1; wb_pc = 32'h40; wb_instr = 32'h0000_006f;
    tick();
    wb_valid = 1'b0; wb_instr = 32'h13;
`ifdef RETIRE_MON_SPIN_DETECT_EN
    check_all("spin", 4'b0110, 1, 1, 32'h40);
`else
    check_all("spin_ignored", 4'b1000, 1, 1, 32'h40);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
